// File: rtl/emin_pkg.sv
// Shared types for the Emin engine and its sequencer.
package emin_pkg;

    localparam int unsigned EminBitWidth = 32;
    localparam int unsigned EminNuValues = 3;

    // Index width for a row/column count of n; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StNext,
        StFin
    } emin_sched_state_t;

    typedef logic [EminNuValues-1:0][EminBitWidth-1:0] t_vec_t;

endpackage

// File: rtl/t_port_arb.sv
// T BRAM read-port arbiter: engine owns the port while a row is active, host otherwise.
module t_port_arb #(
    parameter int unsigned IW        = 8,
    parameter int unsigned T_LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          eng_owns_i,
    input  logic [IW-1:0] eng_treq_i,
    input  logic [IW-1:0] host_treq_i,
    input  logic          host_treq_valid_i,
    output logic          host_grant_o,
    output logic [IW-1:0] t_addr_o,
    output logic          host_tresp_valid_o
);

    logic [T_LATENCY-1:0] pipe_q, pipe_d;

    always_comb begin
        host_grant_o = !eng_owns_i && host_treq_valid_i;
        t_addr_o     = eng_owns_i ? eng_treq_i : host_treq_i;
        // Shift the grant in at bit 0; the top bit is the data-valid for the host.
        pipe_d       = T_LATENCY'({pipe_q, host_grant_o});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign host_tresp_valid_o = pipe_q[T_LATENCY-1];

endmodule

// File: rtl/emin_sched.sv
// Row sequencer for the Emin engine: launches rows, validates result beats,
// forwards them as Emin buffer writes and shares the T read port with the host.
module emin_sched import emin_pkg::*; #(
    parameter  int unsigned BIT_WIDTH = 32,
    parameter  int unsigned I         = 160,
    parameter  int unsigned NU_VALUES = 3,
    parameter  int unsigned T_LATENCY = 2,
    localparam int unsigned IW        = idx_width(I)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                start_in,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                err_out,
    output logic [IW-1:0]                       eng_i_out,
    output logic                                eng_valid_out,
    input  logic [IW-1:0]                       eng_treq_in,
    input  logic [IW-1:0]                       eng_j_in,
    input  logic [BIT_WIDTH-1:0]                eng_data_in,
    input  logic                                eng_valid_in,
    input  logic [IW-1:0]                       host_treq_in,
    input  logic                                host_treq_valid_in,
    output logic                                host_grant_out,
    output logic [IW-1:0]                       t_addr_out,
    input  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] t_resp_in,
    output logic [NU_VALUES-1:0][BIT_WIDTH-1:0] eng_tresp_out,
    output logic [NU_VALUES-1:0][BIT_WIDTH-1:0] host_tresp_out,
    output logic                                host_tresp_valid_out,
    output logic                                wr_en_out,
    output logic [IW-1:0]                       wr_row_out,
    output logic [IW-1:0]                       wr_col_out,
    output logic [BIT_WIDTH-1:0]                wr_data_out
);

    emin_sched_state_t state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     beat_q, beat_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              eng_valid_q, done_q;
    logic              wr_en_q;
    logic [IW-1:0]     wr_row_q, wr_col_q;
    logic [BIT_WIDTH-1:0] wr_data_q;
    logic              beat_accept;
    logic              eng_owns;

    assign beat_accept = (state_q == StRun) && eng_valid_in;
    assign eng_owns    = (state_q == StLaunch) || (state_q == StRun);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        beat_d  = beat_q;
        err_d   = err_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    i_d     = IW'(1);
                    beat_d  = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: state_d = StRun;
            StRun: begin
                if (eng_valid_in) begin
                    if (eng_j_in != beat_q) begin
                        err_d = 1'b1;
                    end
                    beat_d = beat_q + 1'b1;
                    // Row i carries exactly i beats.
                    if (beat_d == i_q) begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (i_q == IW'(I - 1)) begin
                    state_d = StFin;
                end else begin
                    i_d     = i_q + 1'b1;
                    beat_d  = '0;
                    state_d = StLaunch;
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            i_q         <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            eng_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            eng_valid_q <= (state_d == StLaunch);
            done_q      <= (state_d == StFin);
            wr_en_q     <= beat_accept;
            if (beat_accept) begin
                wr_row_q  <= i_q;
                wr_col_q  <= eng_j_in + 1'b1;
                wr_data_q <= eng_data_in;
            end
        end
    end

    t_port_arb #(
        .IW        (IW),
        .T_LATENCY (T_LATENCY)
    ) u_t_port_arb (
        .clk_i              (clk_in),
        .rst_ni             (rst_in),
        .eng_owns_i         (eng_owns),
        .eng_treq_i         (eng_treq_in),
        .host_treq_i        (host_treq_in),
        .host_treq_valid_i  (host_treq_valid_in),
        .host_grant_o       (host_grant_out),
        .t_addr_o           (t_addr_out),
        .host_tresp_valid_o (host_tresp_valid_out)
    );

    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign err_out        = err_q;
    assign eng_i_out      = i_q;
    assign eng_valid_out  = eng_valid_q;
    assign wr_en_out      = wr_en_q;
    assign wr_row_out     = wr_row_q;
    assign wr_col_out     = wr_col_q;
    assign wr_data_out    = wr_data_q;
    assign eng_tresp_out  = t_resp_in;
    assign host_tresp_out = t_resp_in;

endmodule

// File: tb/tb_emin_sched.sv
// Directed/randomised bench for emin_sched; a behavioural engine/host model drives
// the DUT and every output is checked against values derived from the row rules.
module tb_emin_sched;
    import emin_pkg::*;

    // Six rows/columns gives a 3-bit index, wide enough for host address 5.
    localparam int unsigned I  = 6;
    localparam int unsigned BW = 32;
    localparam int unsigned NV = 3;
    localparam int unsigned TL = 2;
    localparam int unsigned IW = idx_width(I);

    logic          clk;
    logic          rst_in, start_in;
    logic          busy_out, done_out, err_out;
    logic [IW-1:0] eng_i_out;
    logic          eng_valid_out;
    logic [IW-1:0] eng_treq_in, eng_j_in;
    logic [BW-1:0] eng_data_in;
    logic          eng_valid_in;
    logic [IW-1:0] host_treq_in;
    logic          host_treq_valid_in, host_grant_out;
    logic [IW-1:0] t_addr_out;
    t_vec_t        t_resp_in, eng_tresp_out, host_tresp_out;
    logic          host_tresp_valid_out;
    logic          wr_en_out;
    logic [IW-1:0] wr_row_out, wr_col_out;
    logic [BW-1:0] wr_data_out;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt = 0, done_cnt = 0, launch_cnt = 0;

    emin_sched #(
        .BIT_WIDTH (BW),
        .I         (I),
        .NU_VALUES (NV),
        .T_LATENCY (TL)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst_in),
        .start_in             (start_in),
        .busy_out             (busy_out),
        .done_out             (done_out),
        .err_out              (err_out),
        .eng_i_out            (eng_i_out),
        .eng_valid_out        (eng_valid_out),
        .eng_treq_in          (eng_treq_in),
        .eng_j_in             (eng_j_in),
        .eng_data_in          (eng_data_in),
        .eng_valid_in         (eng_valid_in),
        .host_treq_in         (host_treq_in),
        .host_treq_valid_in   (host_treq_valid_in),
        .host_grant_out       (host_grant_out),
        .t_addr_out           (t_addr_out),
        .t_resp_in            (t_resp_in),
        .eng_tresp_out        (eng_tresp_out),
        .host_tresp_out       (host_tresp_out),
        .host_tresp_valid_out (host_tresp_valid_out),
        .wr_en_out            (wr_en_out),
        .wr_row_out           (wr_row_out),
        .wr_col_out           (wr_col_out),
        .wr_data_out          (wr_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en_out)     wr_cnt++;
        if (done_out)      done_cnt++;
        if (eng_valid_out) launch_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_err"}, err_out, 0);
        chk({tag, "_eng_i"}, eng_i_out, 0);
        chk({tag, "_eng_valid"}, eng_valid_out, 0);
        chk({tag, "_wr_en"}, wr_en_out, 0);
        chk({tag, "_wr_row"}, wr_row_out, 0);
        chk({tag, "_wr_col"}, wr_col_out, 0);
        chk({tag, "_wr_data"}, wr_data_out, 0);
        chk({tag, "_htv"}, host_tresp_valid_out, 0);
    endtask

    // One full pass. bad_row: beats 0/1 of that row carry swapped j. host_hold: host keeps a
    // request up the whole pass. stray: extra beats in LAUNCH and a start pulse in RUN.
    // abort_row: reset after the first beat of that row.
    task automatic run_pass(input int bad_row, input bit host_hold, input bit stray,
                            input int abort_row);
        int            l0, w0, d0, j, gap;
        bit            exp_err;
        logic [IW-1:0] haddr;
        logic [BW-1:0] data;
        exp_err = 1'b0;
        l0 = launch_cnt;
        w0 = wr_cnt;
        d0 = done_cnt;
        haddr = IW'($urandom_range(0, I - 1));
        @(negedge clk);
        start_in = 1'b1;
        if (host_hold) begin
            host_treq_valid_in = 1'b1;
            host_treq_in       = haddr;
        end
        for (int row = 1; row < I; row++) begin
            @(negedge clk);
            if (row == 1) start_in = 1'b0;
            chk("launch_valid", eng_valid_out, 1);
            chk("launch_row", eng_i_out, row);
            chk("launch_busy", busy_out, 1);
            chk("launch_addr", t_addr_out, eng_treq_in);
            if (host_hold) chk("launch_nogrant", host_grant_out, 0);
            if (stray && row == 2) begin
                eng_valid_in = 1'b1;
                eng_j_in     = '0;
            end
            for (int b = 0; b < row; b++) begin
                gap = int'($urandom_range(1, 3));
                repeat (gap) begin
                    @(negedge clk);
                    chk("gap_wr_en", wr_en_out, 0);
                    chk("gap_eng_valid", eng_valid_out, 0);
                    if (host_hold) chk("run_nogrant", host_grant_out, 0);
                    eng_valid_in = 1'b0;
                end
                j = (row == bad_row && b < 2) ? (b ^ 1) : b;
                if (j != b) exp_err = 1'b1;
                data         = $urandom;
                eng_valid_in = 1'b1;
                eng_j_in     = IW'(j);
                eng_data_in  = data;
                eng_treq_in  = IW'($urandom_range(0, I - 1));
                if (stray && row == 2 && b == 0) start_in = 1'b1;
                #1;
                chk("run_taddr", t_addr_out, eng_treq_in);
                @(negedge clk);
                eng_valid_in = 1'b0;
                start_in     = 1'b0;
                chk("wr_en", wr_en_out, 1);
                chk("wr_row", wr_row_out, row);
                chk("wr_col", wr_col_out, j + 1);
                chk("wr_data", wr_data_out, data);
                if (abort_row == row) begin
                    rst_in = 1'b0;
                    @(negedge clk);
                    chk_all_zero("abort");
                    rst_in = 1'b1;
                    repeat (4) @(negedge clk);
                    chk("abort_no_done", done_cnt - d0, 0);
                    chk("abort_no_relaunch", eng_valid_out, 0);
                    chk("abort_idle_busy", busy_out, 0);
                    return;
                end
            end
            chk("row_end_err", err_out, exp_err);
            chk("row_end_busy", busy_out, 1);
            if (host_hold) begin
                chk("next_grant", host_grant_out, 1);
                chk("next_taddr", t_addr_out, haddr);
            end
        end
        @(negedge clk);
        chk("fin_done", done_out, 1);
        @(negedge clk);
        host_treq_valid_in = 1'b0;
        chk("idle_done", done_out, 0);
        chk("idle_busy", busy_out, 0);
        chk("pass_err", err_out, exp_err);
        chk("pass_launches", launch_cnt - l0, I - 1);
        chk("pass_writes", wr_cnt - w0, I * (I - 1) / 2);
        chk("pass_dones", done_cnt - d0, 1);
    endtask

    initial begin
        bit  hist[$];
        bit  v;
        rst_in             = 1'b0;
        start_in           = 1'b0;
        eng_treq_in        = '0;
        eng_j_in           = '0;
        eng_data_in        = '0;
        eng_valid_in       = 1'b0;
        host_treq_in       = '0;
        host_treq_valid_in = 1'b0;
        t_resp_in          = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_grant", host_grant_out, 0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);

        // Host reads while idle; the first one is address 5.
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("host_tresp_valid", host_tresp_valid_out, (k >= 2) ? hist[k-2] : 1'b0);
            chk("host_tresp_data", host_tresp_out, t_resp_in);
            v                  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            host_treq_valid_in = v;
            host_treq_in       = (k == 0) ? IW'(5) : IW'($urandom_range(0, 7));
            t_resp_in          = {$urandom, $urandom, $urandom};
            #1;
            chk("host_grant", host_grant_out, v);
            chk("host_taddr", t_addr_out, host_treq_in);
            chk("eng_tresp", eng_tresp_out, t_resp_in);
            hist.push_back(v);
        end
        @(negedge clk);
        host_treq_valid_in = 1'b0;
        repeat (3) @(negedge clk);

        // Engine beat while idle is ignored.
        eng_valid_in = 1'b1;
        eng_j_in     = IW'(3);
        @(negedge clk);
        eng_valid_in = 1'b0;
        chk("idle_beat_wr", wr_en_out, 0);
        chk("idle_beat_err", err_out, 0);
        chk("idle_beat_busy", busy_out, 0);

        run_pass(0, 1'b0, 1'b0, 0);
        run_pass(2, 1'b0, 1'b0, 0);
        run_pass(0, 1'b1, 1'b1, 0);
        run_pass(1, 1'b0, 1'b0, 2);
        run_pass(0, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
